axis_mux_alwr: RTL and testbench

- Reverse-direction companion of the AL write demux: merges ADDR_TOTAL AXIS source streams into one AL write channel.
- The winning source index is driven as the word address on the AL write channel.
- Round-robin arbitration; one registered output stage giving full throughput.
- Optional grant lock until tlast, so multi-word bursts reach one address contiguously.

---
 rtl/axis_mux_alwr.sv | 122 ++++++++++++
 tb/tb_axis_mux_alwr.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_mux_alwr.sv
// axis_mux_alwr: round-robin merge of ADDR_TOTAL AXIS sources onto one AL write channel, address = source index.
// Latency: one cycle from a source transfer to its AL write; sustains one word per clock.
// Backpressure: all sources stall while the output register holds a word and m_al_wready is low.
module axis_mux_alwr #(
   parameter int DATA_BITS    = 2,
   parameter int DATA_WIDTH   = 8 << DATA_BITS,
   parameter int ADDR_TOTAL   = 2,
   parameter int ADDR_WIDTH   = $clog2(ADDR_TOTAL) + DATA_BITS,
   parameter int LOCK_ON_LAST = 0
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic [ADDR_TOTAL*DATA_WIDTH-1:0] sn_axis_data,
   input  logic [ADDR_TOTAL-1:0]            sn_axis_valid,
   input  logic [ADDR_TOTAL-1:0]            sn_axis_last,
   output logic [ADDR_TOTAL-1:0]            sn_axis_ready,
   output logic [ADDR_WIDTH-DATA_BITS-1:0]  m_al_waddr,
   output logic [DATA_WIDTH-1:0]            m_al_wdata,
   output logic                             m_al_wvalid,
   input  logic                             m_al_wready
);

   localparam int AW = ADDR_WIDTH - DATA_BITS;

   typedef enum logic {ST_IDLE, ST_LOCKED} state_t;

   state_t        state, state_nxt;
   logic [AW-1:0] lock_src, lock_src_nxt;
   logic [AW-1:0] last_grant;
   logic [AW-1:0] win_idx;
   logic [AW-1:0] cand;
   logic          win_vld;
   logic          win_last;
   logic          load;
   logic          xfer;

   // The output register can take a new word when empty or when its word leaves this cycle.
   assign load     = !m_al_wvalid || m_al_wready;
   assign xfer     = load && win_vld && !rst;
   assign win_last = sn_axis_last[win_idx];

   // Pick the winner: the locked source only, or the first valid source after last_grant.
   always_comb begin
      win_vld = 1'b0;
      win_idx = '0;
      cand    = '0;
      if (state == ST_LOCKED) begin
         win_idx = lock_src;
         win_vld = sn_axis_valid[lock_src];
      end else begin
         for (int k = 1; k <= ADDR_TOTAL; k++) begin
            if (int'(last_grant) + k >= ADDR_TOTAL) cand = AW'(int'(last_grant) + k - ADDR_TOTAL);
            else                                    cand = AW'(int'(last_grant) + k);
            if (!win_vld && sn_axis_valid[cand]) begin
               win_vld = 1'b1;
               win_idx = cand;
            end
         end
      end
   end

   // Ready goes to the winner only, and only while reset is released, so nothing is accepted in reset.
   always_comb begin
      sn_axis_ready = '0;
      if (load && win_vld && !rst) sn_axis_ready[win_idx] = 1'b1;
   end

   // Output stage: reload on every free slot, hold address and data while stalled.
   always_ff @(posedge clk) begin
      if (rst) begin
         m_al_wvalid <= 1'b0;
         m_al_waddr  <= '0;
         m_al_wdata  <= '0;
      end else if (load) begin
         if (win_vld) begin
            m_al_wvalid <= 1'b1;
            m_al_waddr  <= win_idx;
            m_al_wdata  <= sn_axis_data[int'(win_idx)*DATA_WIDTH +: DATA_WIDTH];
         end else begin
            m_al_wvalid <= 1'b0;
         end
      end
   end

   // Round-robin pointer follows the last source that actually transferred.
   always_ff @(posedge clk) begin
      if (rst)       last_grant <= AW'(ADDR_TOTAL - 1);
      else if (xfer) last_grant <= win_idx;
   end

   // Lock state register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= ST_IDLE;
         lock_src <= '0;
      end else begin
         state    <= state_nxt;
         lock_src <= lock_src_nxt;
      end
   end

   // Lock on a non-last word, release when the locked source delivers its last word.
   always_comb begin
      state_nxt    = state;
      lock_src_nxt = lock_src;
      if (LOCK_ON_LAST != 0 && xfer) begin
         case (state)
            ST_IDLE: begin
               if (!win_last) begin
                  state_nxt    = ST_LOCKED;
                  lock_src_nxt = win_idx;
               end
            end
            ST_LOCKED: begin
               if (win_last) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_axis_mux_alwr.sv
// tb_axis_mux_alwr: two instances (4 sources with lock, 3 sources without) against a behavioural model and scoreboard.
// Latency: the model predicts every output one cycle after each acceptance.
// Backpressure: m_al_wready is driven per instance, directed and random.
module tb_axis_mux_alwr;

   localparam int DW = 32;

   logic            clk = 1'b0;
   logic [1:0]      rst;
   logic [1:0]      wready;
   logic [4*DW-1:0] data  [2];
   logic [3:0]      valid [2];
   logic [3:0]      last  [2];

   logic [3:0]    ready_a;
   logic [2:0]    ready_b;
   logic [1:0]    waddr_a, waddr_b;
   logic [DW-1:0] wdata_a, wdata_b;
   logic          wvalid_a, wvalid_b;

   logic [3:0]    ready [2];
   logic [1:0]    waddr [2];
   logic [DW-1:0] wdata [2];
   logic [1:0]    wvalid;

   int errors = 0;
   int checks = 0;
   int cyc    = 0;

   // model state
   int            m_rr [2] = '{3, 2};
   int            m_lk [2] = '{-1, -1};
   bit            m_ov [2] = '{1'b0, 1'b0};
   int            m_oa [2] = '{0, 0};
   logic [DW-1:0] m_od [2] = '{'0, '0};
   logic [DW-1:0] sent_q [8][$];
   int            acc_cnt  [8] = '{default: 0};
   int            seen_cnt [8] = '{default: 0};
   logic [3:0]    took [2] = '{4'b0, 4'b0};
   int            hs_addr [2][$];
   logic [DW-1:0] hs_data [2][$];
   int            hs_cyc  [2][$];

   always #5 clk = ~clk;

   axis_mux_alwr #(.DATA_BITS(2), .ADDR_TOTAL(4), .LOCK_ON_LAST(1)) dut_a (
      .clk(clk), .rst(rst[0]),
      .sn_axis_data(data[0]), .sn_axis_valid(valid[0]), .sn_axis_last(last[0]),
      .sn_axis_ready(ready_a),
      .m_al_waddr(waddr_a), .m_al_wdata(wdata_a), .m_al_wvalid(wvalid_a), .m_al_wready(wready[0])
   );

   axis_mux_alwr #(.DATA_BITS(2), .ADDR_TOTAL(3), .LOCK_ON_LAST(0)) dut_b (
      .clk(clk), .rst(rst[1]),
      .sn_axis_data(data[1][3*DW-1:0]), .sn_axis_valid(valid[1][2:0]), .sn_axis_last(last[1][2:0]),
      .sn_axis_ready(ready_b),
      .m_al_waddr(waddr_b), .m_al_wdata(wdata_b), .m_al_wvalid(wvalid_b), .m_al_wready(wready[1])
   );

   always_comb begin
      ready[0] = ready_a;
      ready[1] = {1'b0, ready_b};
      waddr[0] = waddr_a;
      waddr[1] = waddr_b;
      wdata[0] = wdata_a;
      wdata[1] = wdata_b;
      wvalid   = {wvalid_b, wvalid_a};
   end

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic logic [DW-1:0] word(input int d, input int s, input int k);
      return {8'(16*d + s), 24'(k)};
   endfunction

   // Compare against the model, then advance it by the transfer that the coming edge performs.
   always @(negedge clk) begin
      int n, w, c, q;
      logic [3:0] er;
      bit ld;
      for (int d = 0; d < 2; d++) begin
         n = (d == 0) ? 4 : 3;
         w = -1;
         if (m_lk[d] >= 0) begin
            if (valid[d][m_lk[d]]) w = m_lk[d];
         end else begin
            for (int k = 1; k <= n; k++) begin
               c = (m_rr[d] + k) % n;
               if (w < 0 && valid[d][c]) w = c;
            end
         end
         ld = !m_ov[d] || wready[d];
         er = 4'b0;
         if (ld && w >= 0 && !rst[d]) er[w] = 1'b1;
         check("ready", ready[d], er);
         check("ready_onehot", 64'($countones(ready[d]) <= 1), 1);
         check("wvalid", wvalid[d], m_ov[d]);
         if (m_ov[d]) begin
            check("waddr", waddr[d], m_oa[d]);
            check("wdata", wdata[d], m_od[d]);
         end
         if (wvalid[d] && wready[d] && !rst[d]) begin
            hs_addr[d].push_back(int'(waddr[d]));
            hs_data[d].push_back(wdata[d]);
            hs_cyc[d].push_back(cyc);
            q = d*4 + int'(waddr[d]);
            if (sent_q[q].size() == 0) begin
               checks++;
               errors++;
               $display("FAIL sb_extra: got word 0x%0h on addr %0d, expected none", wdata[d], waddr[d]);
            end else begin
               check("sb_order", wdata[d], sent_q[q].pop_front());
            end
         end
         if (rst[d]) begin
            m_ov[d] = 1'b0;
            m_oa[d] = 0;
            m_od[d] = '0;
            m_rr[d] = n - 1;
            m_lk[d] = -1;
            for (int s = 0; s < 4; s++) sent_q[d*4+s].delete();
         end else if (ld) begin
            if (w >= 0) begin
               m_ov[d] = 1'b1;
               m_oa[d] = w;
               m_od[d] = data[d][w*DW +: DW];
               m_rr[d] = w;
               sent_q[d*4+w].push_back(data[d][w*DW +: DW]);
               acc_cnt[d*4+w]++;
               if (d == 0) begin
                  if (m_lk[d] < 0 && !last[d][w])      m_lk[d] = w;
                  else if (m_lk[d] >= 0 && last[d][w]) m_lk[d] = -1;
               end
            end else begin
               m_ov[d] = 1'b0;
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
      for (int d = 0; d < 2; d++) begin
         for (int s = 0; s < 4; s++) begin
            took[d][s] = (acc_cnt[d*4+s] != seen_cnt[d*4+s]);
            if (took[d][s]) begin
               seen_cnt[d*4+s] = acc_cnt[d*4+s];
               data[d][s*DW +: DW] = word(d, s, seen_cnt[d*4+s]);
            end
         end
      end
   endtask

   task automatic drain();
      valid[0] = 4'b0;
      valid[1] = 4'b0;
      wready   = 2'b11;
      repeat (4) tick();
   endtask

   initial begin
      int rel, mark, cnt_a5;
      rst      = 2'b11;
      wready   = 2'b11;
      valid[0] = 4'hF;
      last[0]  = 4'hF;
      valid[1] = 4'h0;
      last[1]  = 4'h0;
      for (int d = 0; d < 2; d++)
         for (int s = 0; s < 4; s++) data[d][s*DW +: DW] = word(d, s, 0);
      tick();
      tick();

      // reset state, with every source of A offering
      #1;
      check("rst_wvalid", wvalid_a, 0);
      check("rst_waddr", waddr_a, 0);
      check("rst_wdata", wdata_a, 0);
      check("rst_ready_a", ready_a, 0);
      check("rst_ready_b", ready_b, 0);

      // round-robin fairness, all valid, ready high
      rel  = cyc;
      mark = hs_addr[0].size();
      rst  = 2'b00;
      repeat (10) tick();
      check("s1_count_ge8", 64'(hs_addr[0].size() - mark >= 8), 1);
      if (hs_addr[0].size() - mark >= 8) begin
         for (int i = 0; i < 8; i++) begin
            check("s1_addr", hs_addr[0][mark+i], i % 4);
            check("s1_data", hs_data[0][mark+i], word(0, i % 4, i / 4));
            check("s1_cyc", hs_cyc[0][mark+i], rel + 1 + i);
         end
      end
      drain();

      // backpressure hold on source 2
      mark = hs_addr[0].size();
      data[0][2*DW +: DW] = 32'hA5A5_A5A5;
      valid[0]  = 4'b0100;
      last[0]   = 4'b0100;
      wready[0] = 1'b0;
      tick();
      repeat (5) begin
         #1;
         check("s2_wvalid", wvalid_a, 1);
         check("s2_addr", waddr_a, 2);
         check("s2_data", wdata_a, 32'hA5A5_A5A5);
         check("s2_ready", ready_a, 0);
         tick();
      end
      wready[0] = 1'b1;
      tick();
      valid[0] = 4'b0;
      repeat (3) tick();
      cnt_a5 = 0;
      for (int i = mark; i < hs_data[0].size(); i++)
         if (hs_data[0][i] == 32'hA5A5_A5A5) cnt_a5++;
      check("s2_one_write", cnt_a5, 1);
      check("s2_first_addr", hs_addr[0][mark], 2);
      drain();

      // lock on last: 4-word burst from source 1 while source 0 keeps asking
      rst[0] = 1'b1;
      tick();
      rst[0] = 1'b0;
      mark = hs_addr[0].size();
      last[0]  = 4'b0001;
      valid[0] = 4'b0010;
      tick();
      valid[0] = 4'b0011;
      tick();
      valid[0] = 4'b0001;
      repeat (2) begin
         #1;
         check("s3_pause_ready", ready_a, 0);
         tick();
      end
      valid[0] = 4'b0011;
      tick();
      last[0] = 4'b0011;
      tick();
      valid[0] = 4'b0001;
      repeat (3) tick();
      drain();
      check("s3_count_ge5", 64'(hs_addr[0].size() - mark >= 5), 1);
      if (hs_addr[0].size() - mark >= 5) begin
         check("s3_addr0", hs_addr[0][mark+0], 1);
         check("s3_addr1", hs_addr[0][mark+1], 1);
         check("s3_addr2", hs_addr[0][mark+2], 1);
         check("s3_addr3", hs_addr[0][mark+3], 1);
         check("s3_addr4", hs_addr[0][mark+4], 0);
      end

      // same traffic without lock on instance B: interleaves
      mark = hs_addr[1].size();
      last[1]  = 4'b0000;
      valid[1] = 4'b0010;
      tick();
      valid[1] = 4'b0011;
      repeat (6) tick();
      drain();
      check("s4_count_ge7", 64'(hs_addr[1].size() - mark >= 7), 1);
      if (hs_addr[1].size() - mark >= 7) begin
         for (int i = 0; i < 7; i++) check("s4_addr", hs_addr[1][mark+i], (i % 2 == 0) ? 1 : 0);
      end

      // reset while locked on source 3 with a held word
      valid[0] = 4'b1000;
      last[0]  = 4'b0000;
      tick();
      wready[0] = 1'b0;
      #1;
      check("s5_held", wvalid_a, 1);
      rst[0]   = 1'b1;
      valid[0] = 4'hF;
      last[0]  = 4'hF;
      tick();
      #1;
      check("s5_wvalid", wvalid_a, 0);
      check("s5_ready", ready_a, 0);
      rst[0]    = 1'b0;
      wready[0] = 1'b1;
      #1;
      check("s5_first", ready_a, 4'b0001);
      repeat (4) tick();
      drain();

      // random traffic on both instances
      for (int t = 0; t < 10000; t++) begin
         for (int d = 0; d < 2; d++) begin
            for (int s = 0; s < ((d == 0) ? 4 : 3); s++) begin
               if (!(valid[d][s] && !took[d][s])) begin
                  valid[d][s] = ($urandom_range(0, 3) != 0);
                  last[d][s]  = ($urandom_range(0, 3) == 0);
               end
            end
            wready[d] = ($urandom_range(0, 3) != 0);
         end
         tick();
      end
      drain();
      for (int d = 0; d < 2; d++) begin
         int left;
         left = 0;
         for (int s = 0; s < 4; s++) left += sent_q[d*4+s].size();
         check("sb_left", left, 0);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
